// File: rtl/coin_start_sequencer.sv
// Frame-paced coin/start pulse generator: a start request becomes one (P1) or two (P2)
// coin pulses, each followed by a gap, then a start pulse on the requesting player's line.
module coin_start_sequencer #(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic vblank,
    input  logic req_start1,
    input  logic req_start2,
    input  logic inhibit,
    output logic coin_out,
    output logic start1_out,
    output logic start2_out,
    output logic busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COIN_ON,
        ST_COIN_OFF,
        ST_START_ON,
        ST_WAIT_REL
    } state_t;

    localparam logic [7:0] COIN_LAST  = 8'(COIN_FRAMES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
    localparam logic [7:0] START_LAST = 8'(START_FRAMES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_vblank_q;
    logic       r_req1_q;
    logic       r_req2_q;
    logic       r_sel;
    logic       w_sel_next;
    logic [7:0] r_frame_cnt;
    logic [7:0] w_frame_cnt_next;
    logic [1:0] r_coin_left;
    logic [1:0] w_coin_left_next;

    logic       w_tick;
    logic       w_rise1;
    logic       w_rise2;
    logic       w_last;
    logic [7:0] w_limit;

    assign w_tick  = vblank & ~r_vblank_q;
    assign w_rise1 = req_start1 & ~r_req1_q;
    assign w_rise2 = req_start2 & ~r_req2_q;

    // One shared frame counter; the terminal count depends on which phase is running.
    always_comb begin
        w_limit = START_LAST;
        case (r_state)
            ST_COIN_ON:  w_limit = COIN_LAST;
            ST_COIN_OFF: w_limit = GAP_LAST;
            default:     w_limit = START_LAST;
        endcase
    end

    assign w_last = w_tick && (r_frame_cnt == w_limit);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_vblank_q  <= 1'b0;
            r_req1_q    <= 1'b0;
            r_req2_q    <= 1'b0;
            r_sel       <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_coin_left <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_vblank_q  <= vblank;
            r_req1_q    <= req_start1;
            r_req2_q    <= req_start2;
            r_sel       <= w_sel_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_coin_left <= w_coin_left_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sel_next       = r_sel;
        w_frame_cnt_next = r_frame_cnt;
        w_coin_left_next = r_coin_left;

        case (r_state)
            ST_IDLE: begin
                // A tick coinciding with the launch is deliberately not counted.
                if (!inhibit && (w_rise1 || w_rise2)) begin
                    w_sel_next       = w_rise2;
                    w_coin_left_next = w_rise2 ? 2'd2 : 2'd1;
                    w_frame_cnt_next = 8'd0;
                    w_state_next     = ST_COIN_ON;
                end
            end
            ST_COIN_ON: begin
                if (w_last) begin
                    w_frame_cnt_next = 8'd0;
                    w_coin_left_next = r_coin_left - 2'd1;
                    w_state_next     = ST_COIN_OFF;
                end else if (w_tick) begin
                    w_frame_cnt_next = r_frame_cnt + 8'd1;
                end
            end
            ST_COIN_OFF: begin
                if (w_last) begin
                    w_frame_cnt_next = 8'd0;
                    w_state_next     = (r_coin_left != 2'd0) ? ST_COIN_ON : ST_START_ON;
                end else if (w_tick) begin
                    w_frame_cnt_next = r_frame_cnt + 8'd1;
                end
            end
            ST_START_ON: begin
                if (w_last) begin
                    w_frame_cnt_next = 8'd0;
                    w_state_next     = ST_WAIT_REL;
                end else if (w_tick) begin
                    w_frame_cnt_next = r_frame_cnt + 8'd1;
                end
            end
            ST_WAIT_REL: begin
                if (!req_start1 && !req_start2) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Download abort overrides everything, including a tick in the same cycle.
        if (inhibit && (r_state != ST_IDLE)) begin
            w_state_next     = ST_IDLE;
            w_frame_cnt_next = 8'd0;
            w_coin_left_next = 2'd0;
        end
    end

    assign coin_out   = (r_state == ST_COIN_ON);
    assign start1_out = (r_state == ST_START_ON) && !r_sel;
    assign start2_out = (r_state == ST_START_ON) && r_sel;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Bench for coin_start_sequencer: a queue-of-segments pulse-train model predicts the outputs
// every cycle, plus scenario checks on pulse counts and lengths.
module tb_coin_start_sequencer;

    localparam int CF = 2;
    localparam int GF = 3;
    localparam int SF = 2;

    localparam int K_COIN  = 1;
    localparam int K_GAP   = 2;
    localparam int K_START = 3;
    localparam int K_WAIT  = 4;

    logic clk;
    logic reset_n;
    logic vblank;
    logic req_start1;
    logic req_start2;
    logic inhibit;
    logic coin_out;
    logic start1_out;
    logic start2_out;
    logic busy;
    logic [3:0] outs;

    int errors = 0;
    int checks = 0;

    coin_start_sequencer #(
        .COIN_FRAMES (CF),
        .GAP_FRAMES  (GF),
        .START_FRAMES(SF)
    ) dut (
        .clk_sys   (clk),
        .reset_n   (reset_n),
        .vblank    (vblank),
        .req_start1(req_start1),
        .req_start2(req_start2),
        .inhibit   (inhibit),
        .coin_out  (coin_out),
        .start1_out(start1_out),
        .start2_out(start2_out),
        .busy      (busy)
    );

    assign outs = {busy, coin_out, start1_out, start2_out};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VBLANK: high 3 of every 10 cycles, random starting phase.
    int vphase;
    initial begin
        vblank = 1'b0;
        vphase = $urandom_range(0, 9);
        forever begin
            @(negedge clk);
            vphase = (vphase == 9) ? 0 : vphase + 1;
            vblank = (vphase < 3);
        end
    end

    // Reference model: a pending list of (output, frames) segments consumed one frame per tick.
    int   kind_q[$];
    int   ticks_q[$];
    logic m_vq, m_r1q, m_r2q, m_sel;
    logic [3:0] exp_vec;

    initial begin
        logic tick, rise1, rise2;
        int   hd;
        m_vq = 0; m_r1q = 0; m_r2q = 0; m_sel = 0; exp_vec = 4'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                kind_q.delete();
                ticks_q.delete();
                m_vq = 0; m_r1q = 0; m_r2q = 0; m_sel = 0;
            end else begin
                tick  = vblank & ~m_vq;
                rise1 = req_start1 & ~m_r1q;
                rise2 = req_start2 & ~m_r2q;
                if (kind_q.size() == 0) begin
                    if (!inhibit && (rise1 || rise2)) begin
                        m_sel = rise2;
                        repeat (rise2 ? 2 : 1) begin
                            kind_q.push_back(K_COIN); ticks_q.push_back(CF);
                            kind_q.push_back(K_GAP);  ticks_q.push_back(GF);
                        end
                        kind_q.push_back(K_START); ticks_q.push_back(SF);
                        kind_q.push_back(K_WAIT);  ticks_q.push_back(0);
                    end
                end else if (inhibit) begin
                    kind_q.delete();
                    ticks_q.delete();
                end else if (kind_q[0] == K_WAIT) begin
                    if (!req_start1 && !req_start2) begin
                        void'(kind_q.pop_front());
                        void'(ticks_q.pop_front());
                    end
                end else if (tick) begin
                    ticks_q[0] = ticks_q[0] - 1;
                    if (ticks_q[0] == 0) begin
                        void'(kind_q.pop_front());
                        void'(ticks_q.pop_front());
                    end
                end
                m_vq  = vblank;
                m_r1q = req_start1;
                m_r2q = req_start2;
            end
            hd = (kind_q.size() != 0) ? kind_q[0] : 0;
            exp_vec = {kind_q.size() != 0, hd == K_COIN,
                       (hd == K_START) && !m_sel, (hd == K_START) && m_sel};
        end
    end

    task automatic test_reset();
        int seen = 0;
        reset_n = 0; req_start1 = 0; req_start2 = 0; inhibit = 0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (outs !== 4'b0) begin
                errors++; $display("FAIL reset_hold got=%b exp=0000", outs);
            end
        end
        reset_n = 1;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== exp_vec) begin
                errors++; $display("FAIL reset_pre cyc=%0d got=%b exp=%b", c, outs, exp_vec);
            end
            if (coin_out) seen++;
            if (c == 2) req_start1 = 1;
        end
        checks++;
        if (seen < 2) begin
            errors++; $display("FAIL reset_no_coin got=%0d exp=2 coin cycles", seen);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if (outs !== 4'b0) begin
            errors++; $display("FAIL reset_async got=%b exp=0000", outs);
        end
        req_start1 = 0;
        @(negedge clk);
        checks++;
        if (outs !== 4'b0) begin
            errors++; $display("FAIL reset_held got=%b exp=0000", outs);
        end
        reset_n = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== exp_vec || busy !== 1'b0) begin
                errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, outs, exp_vec);
            end
        end
    endtask

    task automatic test_p1();
        int coin_cyc = 0, s1_cyc = 0, s2_cyc = 0;
        int press = 5 + $urandom_range(0, 9);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== exp_vec) begin
                errors++; $display("FAIL p1_cycle cyc=%0d got=%b exp=%b", c, outs, exp_vec);
            end
            coin_cyc += int'(coin_out);
            s1_cyc   += int'(start1_out);
            s2_cyc   += int'(start2_out);
            if (c == 185) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL p1_busy_held got=%b exp=1", busy);
                end
            end
            req_start1 = (c >= press) && (c < 190);
        end
        checks++;
        if (coin_cyc < 11 || coin_cyc > 20) begin
            errors++; $display("FAIL p1_coin_len got=%0d exp=11..20", coin_cyc);
        end
        checks++;
        if (s1_cyc != 20) begin
            errors++; $display("FAIL p1_start1_len got=%0d exp=20", s1_cyc);
        end
        checks++;
        if (s2_cyc != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL p1_end got s2=%0d busy=%b exp s2=0 busy=0", s2_cyc, busy);
        end
    endtask

    // both=1 raises both buttons together; expected result is identical to a P2 press.
    task automatic test_p2(input bit both);
        int coin_cyc = 0, coin_rise = 0, s1_cyc = 0, s2_cyc = 0;
        logic prev_coin = 0;
        int press = 3 + $urandom_range(0, 9);
        for (int c = 0; c < 180; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== exp_vec) begin
                errors++; $display("FAIL p2_cycle both=%0d cyc=%0d got=%b exp=%b", both, c, outs, exp_vec);
            end
            if (coin_out && !prev_coin) coin_rise++;
            prev_coin = coin_out;
            coin_cyc += int'(coin_out);
            s1_cyc   += int'(start1_out);
            s2_cyc   += int'(start2_out);
            req_start2 = (c >= press) && (c < press + 3);
            req_start1 = both && (c >= press) && (c < press + 3);
        end
        checks++;
        if (coin_rise != 2 || coin_cyc < 31 || coin_cyc > 40) begin
            errors++; $display("FAIL p2_coins both=%0d got rises=%0d cyc=%0d exp rises=2 cyc=31..40", both, coin_rise, coin_cyc);
        end
        checks++;
        if (s2_cyc != 20 || s1_cyc != 0) begin
            errors++; $display("FAIL p2_start both=%0d got s2=%0d s1=%0d exp s2=20 s1=0", both, s2_cyc, s1_cyc);
        end
    endtask

    task automatic test_inhibit();
        int coin_cnt = 0, inh_at = -1, busy_after = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== exp_vec) begin
                errors++; $display("FAIL inh_cycle cyc=%0d got=%b exp=%b", c, outs, exp_vec);
            end
            coin_cnt += int'(coin_out);
            if (inh_at >= 0 && c == inh_at + 1) begin
                checks++;
                if (outs !== 4'b0) begin
                    errors++; $display("FAIL inh_abort got=%b exp=0000", outs);
                end
            end
            if (inh_at >= 0 && c > inh_at && c <= 100) busy_after += int'(busy);
            if (c == 111) begin
                checks++;
                if (coin_out !== 1'b1) begin
                    errors++; $display("FAIL inh_repress got=%b exp=1", coin_out);
                end
            end
            if (inh_at < 0 && coin_cnt == 3) inh_at = c;
            inhibit    = (inh_at >= 0) && (c < inh_at + 4);
            req_start1 = ((c >= 2) && (c < 100)) || ((c >= 110) && (c < 115));
        end
        checks++;
        if (inh_at < 0 || busy_after != 0) begin
            errors++; $display("FAIL inh_retrigger got inh_at=%0d busy_cycles=%0d exp busy_cycles=0", inh_at, busy_after);
        end
    endtask

    task automatic test_ignore_press();
        int s1_cyc = 0, s1_rise = 0, coin_rise = 0, sec = -1;
        logic prev_coin = 0, prev_s1 = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== exp_vec) begin
                errors++; $display("FAIL ign_cycle cyc=%0d got=%b exp=%b", c, outs, exp_vec);
            end
            if (coin_out && !prev_coin) coin_rise++;
            if (start1_out && !prev_s1) s1_rise++;
            if (sec < 0 && prev_coin && !coin_out && busy) sec = c;
            prev_coin = coin_out;
            prev_s1   = start1_out;
            s1_cyc   += int'(start1_out);
            req_start1 = ((c >= 2) && (c < 5)) || ((sec >= 0) && (c >= sec) && (c < sec + 3));
        end
        checks++;
        if (sec < 0 || coin_rise != 1 || s1_rise != 1 || s1_cyc != 20) begin
            errors++; $display("FAIL ign_second got sec=%0d coins=%0d s1_pulses=%0d s1_cyc=%0d exp coins=1 s1_pulses=1 s1_cyc=20",
                               sec, coin_rise, s1_rise, s1_cyc);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 250; c++) begin
                @(negedge clk);
                checks++;
                if (outs !== exp_vec) begin
                    errors++; $display("FAIL rand_cycle r=%0d cyc=%0d got=%b exp=%b", r, c, outs, exp_vec);
                end
                if (c < 120) begin
                    if ($urandom_range(0, 19) == 0) req_start1 = ~req_start1;
                    if ($urandom_range(0, 19) == 0) req_start2 = ~req_start2;
                    inhibit = ($urandom_range(0, 59) == 0) ? 1'b1 : (inhibit && ($urandom_range(0, 2) != 0));
                end else begin
                    req_start1 = 0; req_start2 = 0; inhibit = 0;
                end
            end
        end
    endtask

    initial begin
        reset_n = 0; req_start1 = 0; req_start2 = 0; inhibit = 0;
        test_reset();
        test_p1();
        test_p2(1'b0);
        test_p2(1'b1);
        test_inhibit();
        test_ignore_press();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
